// File: rtl/if_stage.sv
// Instruction-fetch stage of the RV32 five-stage pipeline.
// Owns the PC, drives the zero-latency instruction memory address, captures the
// returned word into the IF/ID register, and handles stalls, EX-stage redirects
// and end-of-program drain into a terminal HALT state.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_inst_o,
  output logic        ifid_valid_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] fetch_cnt_o
);

  // The drain counter is 4 bits wide, so the window must fit in 1..15.
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
    $error("if_stage: DRAIN_CYCLES must be in 1..15");
  end

  localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    StRun,
    StPend,
    StHalt
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_inst;
  logic        r_ifid_valid;
  logic        r_halted;
  logic        r_misalign;
  logic [31:0] r_fetch_cnt;
  logic [3:0]  r_drain;

  logic [31:0] w_redirect_pc;
  logic        w_redirect_misalign;
  logic        w_zero_fetch;

  // Targets are forced word-aligned; a dropped low-bit pair is flagged instead.
  assign w_redirect_pc       = {redirect_pc_i[31:2], 2'b00};
  assign w_redirect_misalign = |redirect_pc_i[1:0];
  // An all-zero word (also what out-of-range addresses return) ends the program.
  assign w_zero_fetch        = (imem_inst_i == 32'h0000_0000);

  // Fetch state machine: PC, IF/ID register, drain counter and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StRun;
      r_pc         <= RESET_PC;
      r_ifid_pc    <= 32'h0000_0000;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_misalign   <= 1'b0;
      r_fetch_cnt  <= 32'h0000_0000;
      r_drain      <= 4'd0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (redirect_i) begin
            r_pc         <= w_redirect_pc;
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
            r_misalign   <= r_misalign | w_redirect_misalign;
          end else if (stall_i) begin
            // Hold PC, IF/ID and fetch count.
          end else if (!w_zero_fetch) begin
            r_pc         <= r_pc + 32'd4;
            r_ifid_pc    <= r_pc;
            r_ifid_inst  <= imem_inst_i;
            r_ifid_valid <= 1'b1;
            r_fetch_cnt  <= r_fetch_cnt + 32'd1;
          end else begin
            // End of program seen; give older in-flight branches a window to
            // redirect before committing to HALT.
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
            r_drain      <= DrainInit;
            r_state      <= StPend;
          end
        end

        StPend: begin
          if (redirect_i) begin
            r_pc         <= w_redirect_pc;
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
            r_misalign   <= r_misalign | w_redirect_misalign;
            r_drain      <= 4'd0;
            r_state      <= StRun;
          end else if (stall_i) begin
            // Counter frozen while the pipeline is stalled.
          end else begin
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
            r_drain      <= r_drain - 4'd1;
            if (r_drain == 4'd1) begin
              r_state  <= StHalt;
              r_halted <= 1'b1;
            end
          end
        end

        StHalt: begin
          // Terminal until reset; redirect and stall are ignored.
          r_ifid_pc    <= 32'h0000_0000;
          r_ifid_inst  <= NOP_INST;
          r_ifid_valid <= 1'b0;
          r_halted     <= 1'b1;
        end

        default: begin
          r_state <= StRun;
        end
      endcase
    end
  end

  // Outputs come straight from registers; no input-to-output combinational path.
  assign imem_addr_o  = r_pc;
  assign ifid_pc_o    = r_ifid_pc;
  assign ifid_inst_o  = r_ifid_inst;
  assign ifid_valid_o = r_ifid_valid;
  assign halted_o     = r_halted;
  assign misalign_o   = r_misalign;
  assign fetch_cnt_o  = r_fetch_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: spec-level fetch model checked every cycle, plus directed
// literal expectations from the test plan.
module tb_if_stage;

  localparam logic [31:0] NopInst = 32'h0000_0013;
  localparam int          Drain   = 3;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_inst_o;
  logic        ifid_valid_o;
  logic        halted_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;

  if_stage #(
    .RESET_PC    (32'h0000_0000),
    .NOP_INST    (NopInst),
    .DRAIN_CYCLES(Drain)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_inst_i  (imem_inst_i),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_inst_o  (ifid_inst_o),
    .ifid_valid_o (ifid_valid_o),
    .halted_o     (halted_o),
    .misalign_o   (misalign_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  // 32-word instruction memory; anything at or above 0x80 reads as zero.
  logic [31:0] mem [32];

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if (a < 32'h80) return mem[a[6:2]];
    return 32'h0;
  endfunction

  always_comb imem_inst_i = mem_at(imem_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state of the fetch stage per the rules.
  logic [31:0] m_pc, m_ifid_pc, m_ifid_inst, m_cnt;
  logic        m_valid, m_mis, m_halt;
  int          m_wait;   // edges left in the drain window, 0 when not draining
  bit          m_known = 0;

  always @(posedge clk) begin
    logic [31:0] w;
    if (!rst_n) begin
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_inst = NopInst; m_valid = 1'b0;
      m_cnt = 32'h0; m_mis = 1'b0; m_halt = 1'b0; m_wait = 0; m_known = 1;
    end else if (m_halt) begin
      // frozen until reset
    end else if (redirect_i) begin
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      m_ifid_pc = 32'h0; m_ifid_inst = NopInst; m_valid = 1'b0;
      if (redirect_pc_i % 4 != 0) m_mis = 1'b1;
      m_wait = 0;
    end else if (stall_i) begin
      // hold
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) m_halt = 1'b1;
    end else begin
      w = mem_at(m_pc);
      if (w != 0) begin
        m_ifid_pc = m_pc; m_ifid_inst = w; m_valid = 1'b1;
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end else begin
        m_ifid_pc = 32'h0; m_ifid_inst = NopInst; m_valid = 1'b0;
        m_wait = Drain;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("m_addr",  imem_addr_o,  m_pc);
      chk("m_ifpc",  ifid_pc_o,    m_ifid_pc);
      chk("m_inst",  ifid_inst_o,  m_ifid_inst);
      chk("m_valid", {31'b0, ifid_valid_o}, {31'b0, m_valid});
      chk("m_halt",  {31'b0, halted_o},     {31'b0, m_halt});
      chk("m_mis",   {31'b0, misalign_o},   {31'b0, m_mis});
      chk("m_cnt",   fetch_cnt_o,  m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  imem_addr_o, 32'h0);
    chk({tag, "_ifpc"},  ifid_pc_o, 32'h0);
    chk({tag, "_inst"},  ifid_inst_o, NopInst);
    chk({tag, "_valid"}, {31'b0, ifid_valid_o}, 32'h0);
    chk({tag, "_halt"},  {31'b0, halted_o}, 32'h0);
    chk({tag, "_mis"},   {31'b0, misalign_o}, 32'h0);
    chk({tag, "_cnt"},   fetch_cnt_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20) | 32'h0010_0000;
    mem[0]  = 32'h0A30_0413;
    mem[1]  = 32'hFFC1_0113;
    mem[12] = 32'h0;           // end of program at 0x30

    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    step(); step();
    chk_reset("rst");

    // 1. free run
    rst_n = 1'b1;
    step();
    chk("t1_pc0", ifid_pc_o, 32'h0);
    chk("t1_in0", ifid_inst_o, 32'h0A30_0413);
    chk("t1_v0",  {31'b0, ifid_valid_o}, 32'h1);
    step();
    chk("t1_pc1", ifid_pc_o, 32'h4);
    chk("t1_in1", ifid_inst_o, 32'hFFC1_0113);
    chk("t1_adr", imem_addr_o, 32'h8);
    chk("t1_cnt", fetch_cnt_o, 32'd2);

    // 2. stall at 0x10 for two cycles
    step(); step();
    chk("t2_adr", imem_addr_o, 32'h10);
    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t2_hadr", imem_addr_o, 32'h10);
      chk("t2_hpc",  ifid_pc_o, 32'hC);
      chk("t2_hcnt", fetch_cnt_o, 32'd4);
    end
    stall_i = 1'b0;
    step();
    chk("t2_pc",  ifid_pc_o, 32'h10);
    chk("t2_cnt", fetch_cnt_o, 32'd5);

    // 3. redirect wins over stall at 0x24
    step(); step(); step(); step();
    chk("t3_adr0", imem_addr_o, 32'h24);
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h20;
    step();
    chk("t3_adr", imem_addr_o, 32'h20);
    chk("t3_v",   {31'b0, ifid_valid_o}, 32'h0);
    chk("t3_in",  ifid_inst_o, 32'h0000_0013);
    chk("t3_cnt", fetch_cnt_o, 32'd9);

    // 4. misaligned redirect, then a clean one
    stall_i = 1'b0; redirect_pc_i = 32'h22;
    step();
    chk("t4_adr", imem_addr_o, 32'h20);
    chk("t4_mis", {31'b0, misalign_o}, 32'h1);
    redirect_pc_i = 32'h40;
    step();
    chk("t4_adr2", imem_addr_o, 32'h40);
    chk("t4_mis2", {31'b0, misalign_o}, 32'h1);

    // 5. zero word at 0x30 drains into HALT
    redirect_pc_i = 32'h30;
    step();
    redirect_i = 1'b0;
    step();
    chk("t5_v",   {31'b0, ifid_valid_o}, 32'h0);
    chk("t5_adr", imem_addr_o, 32'h30);
    step(); step();
    chk("t5_nh",  {31'b0, halted_o}, 32'h0);
    step();
    chk("t5_h",    {31'b0, halted_o}, 32'h1);
    chk("t5_hadr", imem_addr_o, 32'h30);
    redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
    step();
    chk("t5_ign",  imem_addr_o, 32'h30);
    chk("t5_h2",   {31'b0, halted_o}, 32'h1);
    chk("t5_mis",  {31'b0, misalign_o}, 32'h1);
    redirect_i = 1'b0; stall_i = 1'b0;

    // 6. redirect out of the drain window, then reset mid-run
    rst_n = 1'b0;
    step();
    chk_reset("rst2");
    rst_n = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h30;
    step();
    redirect_i = 1'b0;
    step();
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0C;
    step();
    redirect_i = 1'b0;
    chk("t6_adr", imem_addr_o, 32'h0C);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_nh", {31'b0, halted_o}, 32'h0);
    end
    chk("t6_adr2", imem_addr_o, 32'h20);
    rst_n = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h45; stall_i = 1'b1;
    step();
    chk_reset("rst3");
    rst_n = 1'b1; redirect_i = 1'b0; stall_i = 1'b0;
    step();

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV32 five-stage pipeline.
- Owns the program counter and drives the combinational instruction memory address.
- Captures the returned word into the IF/ID pipeline register.
- Handles hazard-unit stalls and EX-stage branch/jump redirects.
- Detects end-of-program (all-zero fetch word, including out-of-range addresses) and drains the pipeline into a terminal HALT state.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded at reset.
- NOP_INST, 32'h00000013, bubble word (addi x0,x0,0) loaded into IF/ID on flush.
- DRAIN_CYCLES, 3, cycles to wait after a zero fetch before declaring HALT; an older branch may still redirect during this window. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall_i  in  1  hazard unit: hold PC and IF/ID this cycle
- redirect_i  in  1  EX stage: taken branch/jump this cycle
- redirect_pc_i  in  32  redirect target byte address
- imem_addr_o  out  32  instruction memory byte address (= PC register)
- imem_inst_i  in  32  instruction word from memory, combinational, same cycle
- ifid_pc_o  out  32  PC of the word held in IF/ID
- ifid_inst_o  out  32  instruction held in IF/ID
- ifid_valid_o  out  1  IF/ID holds a real instruction (0 = bubble)
- halted_o  out  1  stage is in HALT
- misalign_o  out  1  sticky: a redirect target had bits [1:0] != 0
- fetch_cnt_o  out  32  count of valid instructions loaded into IF/ID

Behaviour:
- Reset (rst_n=0 at a clock edge) overrides every other input. After the edge:
  - pc=RESET_PC, ifid_pc_o=0, ifid_inst_o=NOP_INST, ifid_valid_o=0
  - halted_o=0, misalign_o=0, fetch_cnt_o=0
  - state=RUN, drain counter=0
- imem_addr_o is the PC register, driven directly with no logic between register and port. The memory read is zero-latency, so the IF/ID capture happens at the next edge.
- States: RUN, PEND, HALT. Priority each edge: reset > redirect > stall > normal.
- RUN, redirect_i=1 (regardless of stall_i):
  - pc <= {redirect_pc_i[31:2],2'b00}
  - IF/ID <= bubble (NOP_INST, valid 0, ifid_pc 0)
  - misalign_o <= misalign_o | (redirect_pc_i[1:0]!=0)
  - fetch_cnt unchanged
- RUN, stall_i=1, no redirect: pc, IF/ID and fetch_cnt all hold.
- RUN, normal, imem_inst_i != 0: IF/ID <= {pc, imem_inst_i, 1}; pc <= pc+4 (mod 2^32); fetch_cnt++ (wraps).
- RUN, normal, imem_inst_i == 0:
  - IF/ID <= bubble; pc held
  - drain counter <= DRAIN_CYCLES; state <= PEND
- PEND:
  - redirect_i=1 → same redirect action as in RUN, counter cleared, state <= RUN.
  - Else stall_i=1 → hold everything, counter frozen.
  - Else counter--; IF/ID stays bubble; pc held. The edge at which the counter goes 1→0 sets state <= HALT.
- HALT:
  - Terminal until reset; redirect_i and stall_i are ignored.
  - pc frozen, IF/ID bubble, halted_o=1 (halted_o is the registered state==HALT).
- Timing example, DRAIN_CYCLES=3: zero word captured at edge N → PEND; halted_o rises after edge N+3 if there is no redirect or stall.
- The out-of-range PC case needs no special handling: memory returns 0, so it takes the halt path.
- misalign_o is sticky until reset and is never cleared by HALT.
- The stall input and the IF/ID register are both edge-sampled; no combinational path from stall_i/redirect_i to the IF/ID outputs.

Test Plan:
1. Reset, then free run; memory returns 0x0A300413 at 0 and 0xFFC10113 at 4.
   - Edge 1: ifid_pc_o=0, ifid_inst_o=0x0A300413, valid=1.
   - Edge 2: ifid_pc_o=4, inst=0xFFC10113.
   - imem_addr_o=8; fetch_cnt_o=2.
2. Stall at pc=0x10 for 2 cycles.
   - imem_addr_o stays 0x10 and IF/ID is unchanged for both cycles.
   - The next edge captures pc 0x10; fetch_cnt increments once only.
3. redirect_i=1 with target 0x20 while stall_i=1 at pc=0x24.
   - Next edge: imem_addr_o=0x20, ifid_valid_o=0, ifid_inst_o=0x00000013.
   - fetch_cnt unchanged.
4. Redirect to 0x22.
   - imem_addr_o=0x20 and misalign_o=1.
   - misalign_o stays 1 after a later clean redirect to 0x40.
5. Zero word at pc=0x30, no redirect.
   - valid=0 from the next edge.
   - halted_o=1 exactly 3 edges later; imem_addr_o held at 0x30.
   - A redirect afterwards is ignored.
6. Zero word at pc=0x30; redirect to 0x0C two edges later (during PEND).
   - Returns to RUN: imem_addr_o=0x0C, halted_o never asserts.
   - Then rst_n=0 mid-run: all outputs at reset values after that edge.
